// File: rtl/monaco_pkg.sv
// Shared types and constants for the NPC collision controller.
// Game-state encoding, start key code and screen bounds.
package monaco_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CRASH,
        OVER
    } game_state_t;

    localparam logic [7:0] KEY_START    = 8'h15;
    localparam int         CAR_W        = 16;
    localparam int         CAR_H        = 32;
    localparam int         SCREEN_X_MIN = 48;
    localparam int         SCREEN_X_MAX = 232;

    // Saturating 16-bit add through a 17-bit sum.
    function automatic logic [15:0] sat_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/npc_collision_ctrl_box_overlap.sv
// Axis-aligned box overlap between two equal-size sprites.
// Touching edges (distance equal to the size) do not count.
module box_overlap #(
    parameter int W = 16,
    parameter int H = 32
) (
    input  logic [9:0] ax,
    input  logic [9:0] ay,
    input  logic [9:0] bx,
    input  logic [9:0] by,
    input  logic       en,
    output logic       hit
);

    localparam logic [10:0] W11 = 11'(W);
    localparam logic [10:0] H11 = 11'(H);

    logic [10:0] dx;
    logic [10:0] dy;

    // Absolute distances on each axis, then the strict overlap test.
    always_comb begin
        dx = 11'd0;
        dy = 11'd0;
        if (ax >= bx) dx = {1'b0, ax} - {1'b0, bx};
        else          dx = {1'b0, bx} - {1'b0, ax};
        if (ay >= by) dy = {1'b0, ay} - {1'b0, by};
        else          dy = {1'b0, by} - {1'b0, ay};
        hit = en & (dx < W11) & (dy < H11);
    end

endmodule

// File: rtl/npc_collision_ctrl.sv
// Crash, lives, game-over and pass-score control for the NPC car.
// All outputs are registered on frame_clk.
module npc_collision_ctrl
    import monaco_pkg::*;
#(
    parameter int CAR_W        = monaco_pkg::CAR_W,
    parameter int CAR_H        = monaco_pkg::CAR_H,
    parameter int CRASH_FRAMES = 90,
    parameter int START_LIVES  = 3,
    parameter int PASS_PTS     = 10
) (
    input  logic        frame_clk,
    input  logic        reset,
    input  logic [7:0]  keycode,
    input  logic [9:0]  playerX,
    input  logic [9:0]  playerY,
    input  logic [9:0]  npcX,
    input  logic [9:0]  npcY,
    input  logic        dispNPC,
    output logic        crash,
    output logic        npc_clear,
    output logic        game_over,
    output logic        running,
    output logic [1:0]  lives,
    output logic [15:0] score
);

    localparam logic [1:0]  LIVES0 = 2'(START_LIVES);
    localparam logic [7:0]  TMR0   = 8'(CRASH_FRAMES - 1);
    localparam logic [15:0] PTS    = 16'(PASS_PTS);

    game_state_t state;
    logic [7:0]  timer;
    logic        disp_q;
    logic        hit;
    logic        pass;

    box_overlap #(
        .W(CAR_W),
        .H(CAR_H)
    ) u_overlap (
        .ax (playerX),
        .ay (playerY),
        .bx (npcX),
        .by (npcY),
        .en (dispNPC),
        .hit(hit)
    );

    assign pass = disp_q & ~dispNPC;

    // Game FSM with timer, lives, score and registered status flags.
    always_ff @(posedge frame_clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= 8'd0;
            disp_q    <= 1'b0;
            lives     <= LIVES0;
            score     <= 16'd0;
            crash     <= 1'b0;
            npc_clear <= 1'b0;
            game_over <= 1'b0;
            running   <= 1'b0;
        end else begin
            disp_q    <= dispNPC;
            npc_clear <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (keycode == KEY_START) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (hit) begin
                        state     <= CRASH;
                        lives     <= lives - 2'd1;
                        npc_clear <= 1'b1;
                        timer     <= TMR0;
                        running   <= 1'b0;
                        crash     <= 1'b1;
                    end else if (pass) begin
                        score <= sat_add(score, PTS);
                    end
                end
                CRASH: begin
                    if (timer == 8'd0) begin
                        crash <= 1'b0;
                        if (lives == 2'd0) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                        end else begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                OVER: begin
                    if (keycode == KEY_START) begin
                        state     <= RUN;
                        lives     <= LIVES0;
                        score     <= 16'd0;
                        game_over <= 1'b0;
                        running   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npc_collision_ctrl.sv
// Scoreboard bench for npc_collision_ctrl.
// Behavioural game model feeds an expectation queue.
module tb_npc_collision_ctrl;

    logic        frame_clk = 1'b0;
    logic        reset;
    logic [7:0]  keycode;
    logic [9:0]  playerX;
    logic [9:0]  playerY;
    logic [9:0]  npcX;
    logic [9:0]  npcY;
    logic        dispNPC;
    logic        crash;
    logic        npc_clear;
    logic        game_over;
    logic        running;
    logic [1:0]  lives;
    logic [15:0] score;

    npc_collision_ctrl dut (
        .frame_clk(frame_clk),
        .reset    (reset),
        .keycode  (keycode),
        .playerX  (playerX),
        .playerY  (playerY),
        .npcX     (npcX),
        .npcY     (npcY),
        .dispNPC  (dispNPC),
        .crash    (crash),
        .npc_clear(npc_clear),
        .game_over(game_over),
        .running  (running),
        .lives    (lives),
        .score    (score)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic        crash;
        logic        clr;
        logic        over;
        logic        run;
        logic [1:0]  lives;
        logic [15:0] score;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // model: mode 0 waiting, 1 playing, 2 crashed, 3 game over
    int m_mode;
    int m_lives;
    int m_score;
    int m_frames;
    bit m_prev;
    bit m_clr;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_edge();
        bit h;
        bit p;
        h = dispNPC
            && iabs(int'(playerX) - int'(npcX)) < 16
            && iabs(int'(playerY) - int'(npcY)) < 32;
        p = m_prev && !dispNPC;
        m_clr = 0;
        if (reset) begin
            m_mode = 0; m_lives = 3; m_score = 0;
            m_frames = 0; m_prev = 0;
        end else begin
            case (m_mode)
                0: if (keycode == 8'h15) m_mode = 1;
                1: begin
                    if (h) begin
                        m_mode = 2; m_lives--; m_clr = 1; m_frames = 0;
                    end else if (p) begin
                        m_score = m_score + 10;
                        if (m_score > 65535) m_score = 65535;
                    end
                end
                2: begin
                    m_frames++;
                    if (m_frames == 90) m_mode = (m_lives == 0) ? 3 : 1;
                end
                default: if (keycode == 8'h15) begin
                    m_mode = 1; m_lives = 3; m_score = 0;
                end
            endcase
            m_prev = dispNPC;
        end
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        e.crash = (m_mode == 2);
        e.clr   = m_clr;
        e.over  = (m_mode == 3);
        e.run   = (m_mode == 1);
        e.lives = 2'(m_lives);
        e.score = 16'(m_score);
        @(posedge frame_clk);
        q.push_back(e);
        #1;
    endtask

    task automatic drive(input logic [7:0] k, input int px, input int py,
                         input int nx, input int ny, input logic d);
        keycode = k;
        playerX = 10'(px);
        playerY = 10'(py);
        npcX    = 10'(nx);
        npcY    = 10'(ny);
        dispNPC = d;
    endtask

    task automatic do_crash();
        drive(8'h00, 100, 200, 110, 180, 1'b1);
        step();
        drive(8'h00, 100, 200, 110, 180, 1'b0);
        repeat (92) step();
    endtask

    task automatic do_pass();
        drive(8'h00, 100, 400, 300, 0, 1'b1);
        step();
        drive(8'h00, 100, 400, 300, 0, 1'b0);
        step();
    endtask

    // Compare every registered output bundle against the queued expectation.
    always @(negedge frame_clk) begin
        exp_t e;
        exp_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {crash, npc_clear, game_over, running, lives, score};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t act crash=%b clr=%b over=%b run=%b lives=%0d score=%h exp crash=%b clr=%b over=%b run=%b lives=%0d score=%h",
                         $time, a.crash, a.clr, a.over, a.run, a.lives, a.score,
                         e.crash, e.clr, e.over, e.run, e.lives, e.score);
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(8'h15, 0, 0, 0, 0, 1'b0);
        repeat (2) step();
        reset = 1'b0;
        drive(8'h00, 100, 200, 300, 0, 1'b0);
        step();
        drive(8'h15, 100, 200, 300, 0, 1'b0);
        repeat (3) step();

        do_crash();

        drive(8'h00, 100, 200, 116, 200, 1'b1);
        repeat (2) step();
        drive(8'h00, 100, 200, 116, 200, 1'b0);
        repeat (2) step();

        drive(8'h00, 100, 200, 300, 200, 1'b1);
        step();
        drive(8'h00, 100, 200, 110, 190, 1'b0);
        step();
        drive(8'h00, 100, 200, 100, 231, 1'b1);
        step();
        drive(8'h00, 100, 200, 100, 232, 1'b1);
        step();

        do_crash();
        do_crash();
        drive(8'h00, 100, 200, 110, 180, 1'b1);
        repeat (3) step();
        drive(8'h15, 100, 400, 300, 0, 1'b0);
        repeat (2) step();

        repeat (6553) do_pass();
        repeat (2) do_pass();

        drive(8'h00, 100, 200, 110, 180, 1'b1);
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(8'h00, 100, 200, 110, 180, 1'b1);
        repeat (2) step();

        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 7) == 0) ? 8'h15 : 8'($urandom),
                  100, 200,
                  int'($urandom_range(80, 120)),
                  int'($urandom_range(160, 240)),
                  1'($urandom_range(0, 2) != 0));
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 1'b0;
        step();

        @(negedge frame_clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
